// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the multicycle controller: state
//               encoding, opcode constants, datapath select encodings, the
//               Moore output bundle and the decode helpers that fill it.
// Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JALR_ADR = 4'd10,
        ST_JUMP     = 4'd11,
        ST_UPPER    = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_rdata  = 2'b01;
    localparam logic [1:0] c_res_alures = 2'b10;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;
    localparam logic [1:0] c_srca_zero  = 2'b11;

    localparam logic [1:0] c_srcb_rs2   = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_four  = 2'b10;

    localparam logic [1:0] c_alu_add    = 2'b00;
    localparam logic [1:0] c_alu_sub    = 2'b01;
    localparam logic [1:0] c_alu_funct  = 2'b10;

    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_b = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b011;
    localparam logic [2:0] c_imm_u = 3'b100;

    // Outputs that depend on the state alone (plus the stable opcode).
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       done;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } moore_t;

    function automatic moore_t moore_outs(input state_t s, input logic [6:0] op);
        moore_t m;
        m = '0;
        case (s)
            ST_FETCH: begin
                m.mem_req    = 1'b1;
                m.result_src = c_res_alures;
                m.alu_src_a  = c_srca_pc;
                m.alu_src_b  = c_srcb_four;
            end
            ST_DECODE: begin
                m.alu_src_a = c_srca_oldpc;
                m.alu_src_b = c_srcb_imm;
            end
            ST_MEMADR, ST_JALR_ADR: begin
                m.alu_src_a = c_srca_rs1;
                m.alu_src_b = c_srcb_imm;
            end
            ST_MEMREAD: begin
                m.mem_req = 1'b1;
                m.adr_src = 1'b1;
            end
            ST_MEMWB: begin
                m.result_src = c_res_rdata;
                m.reg_write  = 1'b1;
                m.done       = 1'b1;
            end
            ST_MEMWRITE: begin
                m.mem_req   = 1'b1;
                m.adr_src   = 1'b1;
                m.mem_write = 1'b1;
            end
            ST_EXECR: begin
                m.alu_src_a = c_srca_rs1;
                m.alu_src_b = c_srcb_rs2;
                m.alu_op    = c_alu_funct;
            end
            ST_EXECI: begin
                m.alu_src_a = c_srca_rs1;
                m.alu_src_b = c_srcb_imm;
                m.alu_op    = c_alu_funct;
            end
            ST_ALUWB: begin
                m.result_src = c_res_aluout;
                m.reg_write  = 1'b1;
                m.done       = 1'b1;
            end
            ST_BRANCH: begin
                m.alu_src_a  = c_srca_rs1;
                m.alu_src_b  = c_srcb_rs2;
                m.alu_op     = c_alu_sub;
                m.result_src = c_res_aluout;
                m.done       = 1'b1;
            end
            ST_JUMP: begin
                // ALU computes the link value PC+4 while ALUOut supplies the target.
                m.alu_src_a  = c_srca_oldpc;
                m.alu_src_b  = c_srcb_four;
                m.result_src = c_res_aluout;
            end
            ST_UPPER: begin
                m.alu_src_a = (op == c_op_lui) ? c_srca_zero : c_srca_oldpc;
                m.alu_src_b = c_srcb_imm;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            c_op_store:           return c_imm_s;
            c_op_branch:          return c_imm_b;
            c_op_jal:             return c_imm_j;
            c_op_lui, c_op_auipc: return c_imm_u;
            default:              return c_imm_i;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Evaluates the branch condition from funct3 and the datapath
//               comparator flags; flags the two reserved funct3 codes.
//   i_funct3  : branch type
//   i_zero    : operands equal
//   i_lt      : signed less-than
//   i_ltu     : unsigned less-than
//   o_taken   : branch condition holds
//   o_illegal : funct3 is not a valid branch type
// Revision    : 1.0  initial release
// ============================================================================
module branch_cond (
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_taken,
    output logic       o_illegal
);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            3'b000:  o_taken   = i_zero;
            3'b001:  o_taken   = ~i_zero;
            3'b100:  o_taken   = i_lt;
            3'b101:  o_taken   = ~i_lt;
            3'b110:  o_taken   = i_ltu;
            3'b111:  o_taken   = ~i_ltu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle RV32I-style control unit. Sequences fetch, decode,
//               memory, ALU, branch and jump steps and drives datapath selects
//               and write enables.
//   Inputs  : clk, rst_n (sync, active-low), opcode, funct3, Zero/LT/LTU
//             comparator flags, mem_ready
//   Outputs : mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
//             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, trap
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       LT,
    input  logic       LTU,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       trap
);

    state_t r_state;
    state_t w_next;
    moore_t r_moore;
    logic   r_trap;
    logic   w_taken;
    logic   w_br_illegal;

    branch_cond u_branch_cond (
        .i_funct3  (funct3),
        .i_zero    (Zero),
        .i_lt      (LT),
        .i_ltu     (LTU),
        .o_taken   (w_taken),
        .o_illegal (w_br_illegal)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:    if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    c_op_load, c_op_store: w_next = ST_MEMADR;
                    c_op_rtype:            w_next = ST_EXECR;
                    c_op_itype:            w_next = ST_EXECI;
                    c_op_branch:           w_next = w_br_illegal ? ST_TRAP : ST_BRANCH;
                    c_op_jal:              w_next = ST_JUMP;
                    c_op_jalr:             w_next = ST_JALR_ADR;
                    c_op_lui, c_op_auipc:  w_next = ST_UPPER;
                    default:               w_next = ST_TRAP;
                endcase
            end
            ST_MEMADR:   w_next = (opcode == c_op_store) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) w_next = ST_MEMWB;
            ST_MEMWB:    w_next = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) w_next = ST_FETCH;
            ST_EXECR:    w_next = ST_ALUWB;
            ST_EXECI:    w_next = ST_ALUWB;
            ST_ALUWB:    w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JALR_ADR: w_next = ST_JUMP;
            ST_JUMP:     w_next = ST_ALUWB;
            ST_UPPER:    w_next = ST_ALUWB;
            ST_TRAP:     w_next = ST_TRAP;
            default:     w_next = ST_FETCH;
        endcase
    end

    // Moore outputs are registered by decoding the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_moore <= moore_outs(ST_FETCH, opcode);
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_moore <= moore_outs(w_next, opcode);
            r_trap  <= (w_next == ST_TRAP);
        end
    end

    // Enables and requests are gated by rst_n so an asserted reset silences
    // them in the same cycle, before the state register has been cleared.
    assign mem_req    = rst_n & r_moore.mem_req;
    assign MemWrite   = rst_n & r_moore.mem_write;
    assign RegWrite   = rst_n & r_moore.reg_write;
    assign IRWrite    = rst_n & (r_state == ST_FETCH) & mem_ready;
    assign PCWrite    = rst_n & (((r_state == ST_FETCH) & mem_ready) |
                                 ((r_state == ST_BRANCH) & w_taken) |
                                 (r_state == ST_JUMP));
    assign instr_done = rst_n & (r_moore.done |
                                 ((r_state == ST_MEMWRITE) & mem_ready));

    assign AdrSrc    = r_moore.adr_src;
    assign ResultSrc = r_moore.result_src;
    assign ALUSrcA   = r_moore.alu_src_a;
    assign ALUSrcB   = r_moore.alu_src_b;
    assign ALUOp     = r_moore.alu_op;
    assign ImmSrc    = imm_src(opcode);
    assign trap      = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each instruction is
//               expanded by a reference model into the expected per-cycle
//               output vectors, which are then compared against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       Zero = 1'b0, LT = 1'b0, LTU = 1'b0, mem_ready = 1'b0;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       instr_done, trap;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    logic [18:0] w_obs;
    assign w_obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, trap};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        mr;
        logic [18:0] v;
    } cyc_t;

    cyc_t        q[$];
    logic [2:0]  m_imm;

    function automatic logic [2:0] ref_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 3'b001;
        if (op == 7'b1100011) return 3'b010;
        if (op == 7'b1101111) return 3'b011;
        if (op == 7'b0110111 || op == 7'b0010111) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            default: return !ltu;
        endcase
    endfunction

    // One expected cycle: mem_ready to drive and every output expected.
    function automatic void push(input logic mr, input logic req, input logic adr,
                                 input logic irw, input logic pcw, input logic mw,
                                 input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [1:0] aop,
                                 input logic done, input logic trp);
        cyc_t c;
        c.mr = mr;
        c.v  = {req, adr, irw, pcw, mw, rw, rs, sa, sb, aop, m_imm, done, trp};
        q.push_back(c);
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Expands one instruction; returns expected retirements.
    function automatic int build(input logic [6:0] op, input logic [2:0] f3,
                                 input logic z, input logic lt, input logic ltu,
                                 input int wf, input int wm);
        q.delete();
        m_imm = ref_imm(op);
        for (int i = 0; i < wf; i++) push(0, 1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0);
        push(1, 1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0);
        push(rnd(), 0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0);
        case (op)
            7'b0000011: begin
                push(rnd(), 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0);
                for (int i = 0; i < wm; i++) push(0, 1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
                push(1, 1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
                push(rnd(), 0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 1,0);
            end
            7'b0100011: begin
                push(rnd(), 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0);
                for (int i = 0; i < wm; i++) push(0, 1,1,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
                push(1, 1,1,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 1,0);
            end
            7'b0110011, 7'b0010011: begin
                push(rnd(), 0,0,0,0,0,0, 2'b00,2'b10, (op == 7'b0110011) ? 2'b00 : 2'b01, 2'b10, 0,0);
                push(rnd(), 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
            end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) return 0;
                push(rnd(), 0,0,0,ref_taken(f3, z, lt, ltu),0,0, 2'b00,2'b10,2'b00,2'b01, 1,0);
            end
            7'b1100111, 7'b1101111: begin
                if (op == 7'b1100111) push(rnd(), 0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0);
                push(rnd(), 0,0,0,1,0,0, 2'b00,2'b01,2'b10,2'b00, 0,0);
                push(rnd(), 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
            end
            7'b0110111, 7'b0010111: begin
                push(rnd(), 0,0,0,0,0,0, 2'b00, (op == 7'b0110111) ? 2'b11 : 2'b01, 2'b01, 2'b00, 0,0);
                push(rnd(), 0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
            end
            default: return 0;
        endcase
        return 1;
    endfunction

    // ---------------- drivers ----------------
    task automatic exec_q(input int n, input string tag, output int dones);
        dones = 0;
        for (int i = 0; i < n && i < q.size(); i++) begin
            mem_ready = q[i].mr;
            #2;
            check($sformatf("%s_c%0d", tag, i), 32'(w_obs), 32'(q[i].v));
            if (instr_done) dones++;
            @(posedge clk); #2;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mem_ready = rnd();
        #2;
        check({tag, "_rst_en"}, {26'd0, mem_req, MemWrite, RegWrite, IRWrite, PCWrite, instr_done}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        check({tag, "_rst_fetch"}, 32'(w_obs),
              32'({1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00, ref_imm(opcode),1'b0,1'b0}));
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input logic lt, input logic ltu,
                             input int wf, input int wm);
        int exp_done, got_done;
        opcode = op; funct3 = f3; Zero = z; LT = lt; LTU = ltu;
        exp_done = build(op, f3, z, lt, ltu, wf, wm);
        if (exp_done == 0) begin
            // Instruction is illegal: expect trap, silence on the bus, then reset.
            for (int i = 0; i < 4; i++) push(rnd(), 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1);
        end
        exec_q(q.size(), tag, got_done);
        check({tag, "_retire"}, 32'(got_done), 32'(exp_done));
        if (exp_done == 0) do_reset(tag);
    endtask

    localparam logic [6:0] c_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        int d;
        logic [6:0] op;
        @(posedge clk); #2;
        @(posedge clk); #2;
        do_reset("init");

        run_instr("add",  7'b0110011, 3'd0, 0,0,0, 0, 0);
        run_instr("lw",   7'b0000011, 3'd2, 0,0,0, 0, 3);
        run_instr("bne0", 7'b1100011, 3'd1, 0,0,0, 0, 0);
        run_instr("bne1", 7'b1100011, 3'd1, 1,0,0, 0, 0);
        run_instr("jalr", 7'b1100111, 3'd0, 0,0,0, 0, 0);
        run_instr("ill",  7'b1111111, 3'd0, 0,0,0, 0, 0);
        run_instr("brres",7'b1100011, 3'd2, 0,0,0, 1, 0);

        // Store aborted by reset while waiting on memory.
        opcode = 7'b0100011; funct3 = 3'd2;
        d = build(7'b0100011, 3'd2, 0, 0, 0, 0, 5);
        exec_q(4, "swabort", d);
        check("swabort_retire", 32'(d), 32'd0);
        do_reset("swabort");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                for (int k = 0; k < 9; k++) if (op == c_ops[k]) op = 7'b1111111;
            end else begin
                op = c_ops[$urandom_range(0, 8)];
            end
            run_instr($sformatf("rnd%0d", n), op, 3'($urandom), rnd(), rnd(), rnd(),
                      $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL use one clock clk (rising edge); reset rst_n is synchronous and active-low; no parameters.
REQ-002 clk  in  1  clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 opcode  in  7  instruction register bits [6:0], stable from DECODE until FETCH.
REQ-005 funct3  in  3  instruction register bits [14:12].
REQ-006 Zero, LT, LTU  in  1 each  datapath comparator flags: equal, signed-less, unsigned-less.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 mem_req  out  1  memory access request, held until mem_ready.
REQ-009 AdrSrc  out  1  memory address: 0=PC, 1=ALUOut.
REQ-010 IRWrite, PCWrite, MemWrite, RegWrite  out  1 each  register and memory write enables.
REQ-011 ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALU result.
REQ-012 ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 register, 11=zero.
REQ-013 ALUSrcB  out  2  00=rs2 register, 01=immediate, 10=constant 4.
REQ-014 ALUOp  out  2  00=add, 01=subtract/compare, 10=funct-decoded, 11 unused.
REQ-015 ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
REQ-016 instr_done  out  1  one-cycle pulse on each retired instruction.
REQ-017 trap  out  1  sticky illegal-instruction flag.

Function
REQ-018 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALR_ADR, JUMP, UPPER, TRAP.
REQ-019 Outputs are Moore, from state only, except PCWrite, IRWrite and instr_done, which also use mem_ready/taken; unlisted outputs are 0; ImmSrc is decoded from opcode in every state.
REQ-020 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay while !mem_ready, else go to DECODE.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
REQ-022 DECODE next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JUMP; 1100111 -> JALR_ADR; 0110111/0010111 -> UPPER; any other -> TRAP.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; load -> MEMREAD, store -> MEMWRITE.
REQ-024 MEMREAD: mem_req=1, AdrSrc=1; hold until mem_ready, then go to MEMWB.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1; then go to FETCH.
REQ-026 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1; hold until mem_ready, then instr_done=1 and go to FETCH.
REQ-027 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
REQ-028 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; then go to FETCH.
REQ-029 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken, instr_done=1; then go to FETCH.
REQ-030 taken by funct3: 000 Zero, 001 !Zero, 100 LT, 101 !LT, 110 LTU, 111 !LTU; funct3 010/011 in DECODE with a branch opcode -> TRAP.
REQ-031 JALR_ADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; then go to JUMP.
REQ-032 JUMP: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (target from ALUOut, link value into ALUOut); then go to ALUWB.
REQ-033 UPPER: ALUSrcA=11 (LUI) or 01 (AUIPC), ALUSrcB=01, ALUOp=00; then go to ALUWB.
REQ-034 TRAP: trap=1; all enables and mem_req are 0; absorbing until reset.
REQ-035 An instruction retires exactly once; mem_ready outside a mem_req state is ignored.

Reset
REQ-036 rst_n low at a clock edge -> state FETCH, trap=0; this aborts any state, including waits.
REQ-037 While rst_n is low, all write enables, mem_req and instr_done are forced to 0 combinationally.

Structure
REQ-038 ctrl_pkg holds the state enum, opcode constants, and the ResultSrc/ALUSrc/ALUOp/ImmSrc encodings.
REQ-039 Branch condition evaluation is a sub-module, branch_cond (funct3, Zero, LT, LTU -> taken, illegal).

Verification
REQ-040 Scenario: add (0110011), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; RegWrite on the 4th cycle; instr_done once.
REQ-041 Scenario: lw, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req=1; MEMWB RegWrite with ResultSrc=01.
REQ-042 Scenario: bne, Zero=0 -> PCWrite=1 in BRANCH; with Zero=1 -> PCWrite=0; RegWrite=0 throughout.
REQ-043 Scenario: jalr -> DECODE, JALR_ADR, JUMP (PCWrite=1), ALUWB (RegWrite=1).
REQ-044 Scenario: opcode 1111111 -> TRAP, trap=1, no further mem_req; rst_n low one cycle -> FETCH, trap=0.
REQ-045 Scenario: rst_n low during MEMWRITE wait -> MemWrite=0 that cycle; FETCH next cycle.
